cmos_pixel_packer: RTL
======================

CMOS_PIXEL_PACKER -- requirements
Module: cmos_pixel_packer

Interface
REQ-001 Parameter IN_W, default 8: width in bits of one sensor byte on pdata_i.
REQ-002 Parameter BYTES_PER_PIX, default 2, legal 1..4: number of input bytes that make one output pixel.
REQ-003 Parameter MSB_FIRST, default 1: 1 places the first byte of a pixel in the MSBs of pdata_o; 0 places it in the LSBs.
REQ-004 Parameter CNT_W, default 12: width of the statistics counters.
REQ-005 Port pclk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port vs_i, input, 1: sensor vertical sync, active-high.
REQ-008 Port de_i, input, 1: sensor byte-valid (href).
REQ-009 Port pdata_i, input, IN_W: sensor byte.
REQ-010 Port pix_vld_o, output, 1: one-cycle strobe, pdata_o holds a new pixel.
REQ-011 Port pdata_o, output, IN_W*BYTES_PER_PIX: packed pixel.
REQ-012 Port sof_o, output, 1: high together with the first pix_vld_o of a frame.
REQ-013 Port eol_o, output, 1: one-cycle pulse marking end of line.
REQ-014 Port vs_o, output, 1: vs_i delayed by 1 cycle.
REQ-015 Port odd_err_o, output, 1: one-cycle pulse, line ended with a partial pixel.
REQ-016 Ports line_cnt_o and pix_cnt_o, output, CNT_W each: frame statistics; present only with CMOS_PACK_STAT_EN.

Function
REQ-017 FSM states: IDLE, WAIT_VS, ACTIVE; IDLE goes to WAIT_VS one cycle after reset release.
REQ-018 WAIT_VS goes to ACTIVE on the first vs_i rising edge, detected from a 1-cycle registered copy of vs_i; de_i is ignored in IDLE and WAIT_VS.
REQ-019 In ACTIVE, every cycle with de_i=1 accepts pdata_i into the shift register and advances byte counter bcnt, which runs 0..BYTES_PER_PIX-1 and wraps to 0.
REQ-020 When the byte with bcnt=BYTES_PER_PIX-1 is accepted, pdata_o and pix_vld_o update on the next clock edge, giving a latency of 1 cycle from the final byte.
REQ-021 pdata_o holds its last value between strobes; with BYTES_PER_PIX=1 every accepted byte produces a pixel.
REQ-022 A de_i falling edge (de_i=0 while the registered de_i=1) in ACTIVE raises eol_o on the next cycle.
REQ-023 At a de_i falling edge with bcnt!=0, the partial pixel is discarded, bcnt clears to 0, and odd_err_o pulses in the same cycle as eol_o.
REQ-024 A vs_i rising edge in ACTIVE clears bcnt and discards any partial pixel without odd_err_o, and re-arms sof_o; the FSM stays in ACTIVE.
REQ-025 If a vs_i rising edge and a final byte occur in the same cycle, the vs_i edge wins: no pix_vld_o is produced and bcnt goes to 0.
REQ-026 sof_o is set by every vs_i rising edge and clears after the first pix_vld_o that follows.

Reset
REQ-027 While rst=1: FSM=IDLE, bcnt=0, the sof re-arm flag=0, edge registers=0, and every output is 0 including pdata_o and the statistics outputs.
REQ-028 Asserting rst mid-line or mid-pixel takes effect on the next edge; after release, capture resumes only after a new vs_i rising edge.

Configuration
REQ-029 With CMOS_PACK_STAT_EN defined: per frame, an internal line counter counts eol_o events and a pixel counter counts pix_vld_o in the current line; both saturate at 2^CNT_W-1.
REQ-030 With CMOS_PACK_STAT_EN defined: at each vs_i rising edge, line_cnt_o captures the line count; at each eol_o, pix_cnt_o captures that line's pixel count; the internal counters then clear.
REQ-031 Without CMOS_PACK_STAT_EN, the statistics ports, counters and logic do not exist; all other behaviour is identical.

Structure
REQ-032 Shared package cmos_pack_pkg holds the FSM state typedef (IDLE, WAIT_VS, ACTIVE) and the BYTES_PER_PIX legal-range constants.
REQ-033 One sub-module, cmos_edge_det (1-bit register plus rise and fall outputs), is instantiated for vs_i and for de_i.

Verification
REQ-034 Bench scenario: defaults, de_i high for 4 cycles with bytes A1,B2,C3,D4 before any vs_i edge -> no pix_vld_o; after a vs_i pulse, the same line -> pdata_o=A1B2 then C3D4, one cycle after B2 and after D4, with sof_o on the first.
REQ-035 Bench scenario: MSB_FIRST=0, bytes 11,22 -> pdata_o=2211.
REQ-036 Bench scenario: 3-byte line 01,02,03 with BYTES_PER_PIX=2 -> one pixel 0102, then eol_o and odd_err_o together 1 cycle after de_i falls; the next line starts clean.
REQ-037 Bench scenario: BYTES_PER_PIX=3, 6 bytes -> 2 strobes; BYTES_PER_PIX=1 -> one strobe per byte.
REQ-038 Bench scenario: rst asserted after 1 byte of a pixel -> all outputs 0 on the next edge; after release, data before the next vs_i edge is ignored.
REQ-039 Bench scenario: CMOS_PACK_STAT_EN, CNT_W=4, a frame of 3 lines x 20 pixels -> pix_cnt_o=15 (saturated) at each eol_o, line_cnt_o=3 at the next vs_i edge.

Source files
------------

// File: rtl/cmos_pack_pkg.sv
// Shared definitions for the CMOS pixel packer.
//
// Contents:
//   state_t  - capture FSM states (IDLE, WAIT_VS, ACTIVE)
//   BPP_MIN  - smallest legal BYTES_PER_PIX
//   BPP_MAX  - largest legal BYTES_PER_PIX
//   BCNT_W   - width of the byte-in-pixel counter (covers 0..BPP_MAX-1)
package cmos_pack_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam int BPP_MIN = 1;
  localparam int BPP_MAX = 4;
  localparam int BCNT_W  = 2;

endpackage

// File: rtl/cmos_edge_det.sv
// Single-bit edge detector: one register stage plus combinational rise and
// fall flags comparing the live input against its registered copy.
//
// Ports:
//   clk  - clock, rising edge
//   srst - synchronous active-high reset (clears the register)
//   d    - input level
//   q    - d delayed by one clock
//   rise - d=1 while q=0
//   fall - d=0 while q=1
module cmos_edge_det (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic d_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      d_reg <= 1'b0;
    end else begin
      d_reg <= d;
    end
  end

  assign q    = d_reg;
  assign rise = d & ~d_reg;
  assign fall = ~d & d_reg;

endmodule

// File: rtl/cmos_pixel_packer.sv
// Packs bytes from a parallel CMOS sensor port (vsync / href / data) into
// whole pixels of BYTES_PER_PIX bytes, with frame and line markers.
//
// Capture only starts after the first vsync rising edge following reset.
// A pixel is emitted one clock after its final byte is accepted. A line that
// ends on a partial pixel drops the partial bytes and flags odd_err_o
// together with eol_o. A vsync rising edge restarts pixel alignment silently
// and re-arms sof_o for the next emitted pixel.
//
// Parameters:
//   IN_W          - sensor byte width
//   BYTES_PER_PIX - bytes per output pixel, 1..4
//   MSB_FIRST     - 1: first byte lands in the MSBs of pdata_o, 0: in the LSBs
//   CNT_W         - statistics counter width
//
// Ports:
//   pclk        - clock, rising edge
//   rst         - synchronous active-high reset
//   vs_i        - sensor vsync, active-high
//   de_i        - sensor byte valid (href)
//   pdata_i     - sensor byte
//   pix_vld_o   - one-cycle strobe, pdata_o carries a new pixel
//   pdata_o     - packed pixel, held between strobes
//   sof_o       - marks the first pixel after a vsync rising edge
//   eol_o       - one-cycle end-of-line pulse
//   vs_o        - vs_i delayed by one clock
//   odd_err_o   - one-cycle pulse, line ended on a partial pixel
//   line_cnt_o  - lines in the previous frame (CMOS_PACK_STAT_EN only)
//   pix_cnt_o   - pixels in the previous line (CMOS_PACK_STAT_EN only)
//
// Build option: define CMOS_PACK_STAT_EN to add the saturating line / pixel
// statistics counters and their output ports.
module cmos_pixel_packer
  import cmos_pack_pkg::*;
#(
  parameter int IN_W          = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int CNT_W         = 12
) (
  input  logic                          pclk,
  input  logic                          rst,
  input  logic                          vs_i,
  input  logic                          de_i,
  input  logic [IN_W-1:0]               pdata_i,
  output logic                          pix_vld_o,
  output logic [IN_W*BYTES_PER_PIX-1:0] pdata_o,
  output logic                          sof_o,
  output logic                          eol_o,
  output logic                          vs_o,
  output logic                          odd_err_o
`ifdef CMOS_PACK_STAT_EN
  ,
  output logic [CNT_W-1:0]              line_cnt_o,
  output logic [CNT_W-1:0]              pix_cnt_o
`endif
);

  localparam int PIX_W = IN_W * BYTES_PER_PIX;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES_PER_PIX - 1);

  if (BYTES_PER_PIX < BPP_MIN || BYTES_PER_PIX > BPP_MAX) begin : g_bad_bpp
    $error("cmos_pixel_packer: BYTES_PER_PIX must be within 1..4");
  end

  // ---------------------------------------------------------------------
  // Sync edge detection
  // ---------------------------------------------------------------------
  logic vs_q, vs_rise, vs_fall;
  logic de_q, de_rise, de_fall;

  cmos_edge_det u_vs_edge (
    .clk  (pclk),
    .srst (rst),
    .d    (vs_i),
    .q    (vs_q),
    .rise (vs_rise),
    .fall (vs_fall)
  );

  cmos_edge_det u_de_edge (
    .clk  (pclk),
    .srst (rst),
    .d    (de_i),
    .q    (de_q),
    .rise (de_rise),
    .fall (de_fall)
  );

  // Edge outputs this block has no use for.
  logic unused_edges;
  assign unused_edges = ^{vs_fall, de_rise, de_q};

  assign vs_o = vs_q;

  // ---------------------------------------------------------------------
  // Capture FSM and byte counter
  // ---------------------------------------------------------------------
  state_t            state_reg, state_next;
  logic [BCNT_W-1:0] bcnt_reg, bcnt_next;
  logic              sof_arm_reg, sof_arm_next;
  logic              accept;
  logic              last_byte;
  logic              line_end;
  logic              partial_drop;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg   <= IDLE;
      bcnt_reg    <= '0;
      sof_arm_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bcnt_reg    <= bcnt_next;
      sof_arm_reg <= sof_arm_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcnt_next    = bcnt_reg;
    sof_arm_next = sof_arm_reg;
    accept       = 1'b0;
    last_byte    = 1'b0;
    line_end     = 1'b0;
    partial_drop = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = WAIT_VS;
      end
      WAIT_VS: begin
        if (vs_rise) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // A byte arriving with a vsync edge belongs to no frame: the edge
        // wins and the byte is dropped.
        accept       = de_i & ~vs_rise;
        last_byte    = accept & (bcnt_reg == BCNT_LAST);
        line_end     = de_fall;
        partial_drop = de_fall & (bcnt_reg != '0) & ~vs_rise;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // accept (de_i=1) and line_end (de_i=0) are mutually exclusive.
    if (vs_rise || line_end) begin
      bcnt_next = '0;
    end else if (accept) begin
      bcnt_next = last_byte ? '0 : bcnt_reg + BCNT_W'(1);
    end

    // vs_rise and last_byte never coincide, so the order is immaterial.
    if (vs_rise) begin
      sof_arm_next = 1'b1;
    end else if (last_byte) begin
      sof_arm_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Byte slots: every byte except the last is parked in its own register;
  // the last one is taken straight from pdata_i so the pixel is ready on
  // the edge that accepts it.
  // ---------------------------------------------------------------------
  logic [PIX_W-1:0] pix_next;

  for (genvar gi = 0; gi < BYTES_PER_PIX; gi++) begin : g_slot
    localparam int POS = (MSB_FIRST != 0) ? (BYTES_PER_PIX - 1 - gi) : gi;

    if (gi == BYTES_PER_PIX - 1) begin : g_last
      assign pix_next[POS*IN_W +: IN_W] = pdata_i;
    end else begin : g_hold
      logic [IN_W-1:0] byte_reg;

      always_ff @(posedge pclk) begin
        if (rst) begin
          byte_reg <= '0;
        end else if (accept && (bcnt_reg == BCNT_W'(gi))) begin
          byte_reg <= pdata_i;
        end
      end

      assign pix_next[POS*IN_W +: IN_W] = byte_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge pclk) begin
    if (rst) begin
      pix_vld_o <= 1'b0;
      pdata_o   <= '0;
      sof_o     <= 1'b0;
      eol_o     <= 1'b0;
      odd_err_o <= 1'b0;
    end else begin
      pix_vld_o <= last_byte;
      sof_o     <= last_byte & sof_arm_reg;
      eol_o     <= line_end;
      odd_err_o <= partial_drop;
      if (last_byte) begin
        pdata_o <= pix_next;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Frame statistics
  // ---------------------------------------------------------------------
`ifdef CMOS_PACK_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] line_acc_reg, pix_acc_reg;
  logic [CNT_W-1:0] line_total, pix_total;

  // Running totals including this cycle's event, so an eol_o or pix_vld_o
  // that lands on the capture cycle is still counted in the closing period.
  always_comb begin
    line_total = line_acc_reg;
    pix_total  = pix_acc_reg;
    if (eol_o && (line_acc_reg != CNT_MAX)) begin
      line_total = line_acc_reg + CNT_W'(1);
    end
    if (pix_vld_o && (pix_acc_reg != CNT_MAX)) begin
      pix_total = pix_acc_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      line_acc_reg <= '0;
      pix_acc_reg  <= '0;
      line_cnt_o   <= '0;
      pix_cnt_o    <= '0;
    end else begin
      if (vs_rise) begin
        line_cnt_o   <= line_total;
        line_acc_reg <= '0;
      end else begin
        line_acc_reg <= line_total;
      end

      if (eol_o) begin
        pix_cnt_o   <= pix_total;
        pix_acc_reg <= '0;
      end else if (vs_rise) begin
        pix_acc_reg <= '0;
      end else begin
        pix_acc_reg <= pix_total;
      end
    end
  end
`else
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cmos_pixel_packer: CNT_W must be at least 1");
  end
`endif

endmodule
